// File: rtl/circle_hit_pipe.sv
// circle_hit_pipe: tests a stream of points against N_CIRCLES programmable
// circles through a 3-stage pipeline (difference, square, compare).
// Optional feature macro: CIRCLE_RING_EN adds a per-circle inner radius so
// that each circle becomes an annulus (ri^2 <= d^2 < r^2).
//
// Handshake: in_valid qualifies x/y on the rising edge and there is no
// backpressure. out_valid pulses for exactly one cycle per accepted sample,
// 3 cycles after capture and in input order. in_circle/any_hit change only
// when out_valid is high and hold their value otherwise.
module circle_hit_pipe #(
  parameter int W         = 10,
  parameter int N_CIRCLES = 4,
  parameter int DEF_CX    = 320,
  parameter int DEF_CY    = 240,
  parameter int DEF_R     = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W-1:0]         x,
  input  logic [W-1:0]         y,
  input  logic                 in_valid,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_idx,
  input  logic [W-1:0]         cfg_cx,
  input  logic [W-1:0]         cfg_cy,
  input  logic [W-1:0]         cfg_r,
`ifdef CIRCLE_RING_EN
  input  logic [W-1:0]         cfg_ri,
`endif
  output logic                 out_valid,
  output logic [N_CIRCLES-1:0] in_circle,
  output logic                 any_hit
);

  localparam int PW = 2*W + 2;  // squared-term width
  localparam int DW = 2*W + 3;  // sum-of-squares width, cannot overflow
  localparam logic [W-1:0] L_DEF_CX = W'(DEF_CX);
  localparam logic [W-1:0] L_DEF_CY = W'(DEF_CY);
  localparam logic [W-1:0] L_DEF_R  = W'(DEF_R);

  // Configuration registers
  logic [W-1:0] r_cx [N_CIRCLES];
  logic [W-1:0] r_cy [N_CIRCLES];
  logic [W-1:0] r_r  [N_CIRCLES];

  // Stage 1: signed differences (two's complement, W+1 bits)
  logic         r_s1_valid;
  logic [W:0]   r_s1_dx [N_CIRCLES];
  logic [W:0]   r_s1_dy [N_CIRCLES];
  logic [W-1:0] r_s1_r  [N_CIRCLES];
  logic [W:0]   w_dx    [N_CIRCLES];
  logic [W:0]   w_dy    [N_CIRCLES];

  // Stage 2: squares
  logic          r_s2_valid;
  logic [PW-1:0] r_s2_dx2 [N_CIRCLES];
  logic [PW-1:0] r_s2_dy2 [N_CIRCLES];
  logic [PW-1:0] r_s2_r2  [N_CIRCLES];
  logic [PW-1:0] w_dx2    [N_CIRCLES];
  logic [PW-1:0] w_dy2    [N_CIRCLES];
  logic [PW-1:0] w_r2     [N_CIRCLES];

  // Stage 3: compare and output registers
  logic [DW-1:0]        w_d2 [N_CIRCLES];
  logic [N_CIRCLES-1:0] w_hit;
  logic                 r_out_valid;
  logic [N_CIRCLES-1:0] r_in_circle;
  logic                 r_any_hit;

`ifdef CIRCLE_RING_EN
  logic [W-1:0]  r_ri     [N_CIRCLES];
  logic [W-1:0]  r_s1_ri  [N_CIRCLES];
  logic [PW-1:0] r_s2_ri2 [N_CIRCLES];
  logic [PW-1:0] w_ri2    [N_CIRCLES];
`endif

  // Circle parameter storage; out-of-range indices match no entry and are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CIRCLES; i++) begin
        r_cx[i] <= L_DEF_CX;
        r_cy[i] <= L_DEF_CY;
        r_r[i]  <= L_DEF_R;
`ifdef CIRCLE_RING_EN
        r_ri[i] <= '0;
`endif
      end
    end else if (cfg_we) begin
      for (int i = 0; i < N_CIRCLES; i++) begin
        if (cfg_idx == 4'(i)) begin
          r_cx[i] <= cfg_cx;
          r_cy[i] <= cfg_cy;
          r_r[i]  <= cfg_r;
`ifdef CIRCLE_RING_EN
          r_ri[i] <= cfg_ri;
`endif
        end
      end
    end
  end

  // Stage 1 differences; zero-extend then subtract gives a signed W+1 result
  always_comb begin
    for (int i = 0; i < N_CIRCLES; i++) begin
      w_dx[i] = {1'b0, x} - {1'b0, r_cx[i]};
      w_dy[i] = {1'b0, y} - {1'b0, r_cy[i]};
    end
  end

  // Stage 1 register: captures differences and the current radius on a valid sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      for (int i = 0; i < N_CIRCLES; i++) begin
        r_s1_dx[i] <= '0;
        r_s1_dy[i] <= '0;
        r_s1_r[i]  <= '0;
`ifdef CIRCLE_RING_EN
        r_s1_ri[i] <= '0;
`endif
      end
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < N_CIRCLES; i++) begin
          r_s1_dx[i] <= w_dx[i];
          r_s1_dy[i] <= w_dy[i];
          r_s1_r[i]  <= r_r[i];
`ifdef CIRCLE_RING_EN
          r_s1_ri[i] <= r_ri[i];
`endif
        end
      end
    end
  end

  // Stage 2 squares; sign-extending to PW bits makes the truncated product exact
  always_comb begin
    for (int i = 0; i < N_CIRCLES; i++) begin
      w_dx2[i] = {{(W+1){r_s1_dx[i][W]}}, r_s1_dx[i]} * {{(W+1){r_s1_dx[i][W]}}, r_s1_dx[i]};
      w_dy2[i] = {{(W+1){r_s1_dy[i][W]}}, r_s1_dy[i]} * {{(W+1){r_s1_dy[i][W]}}, r_s1_dy[i]};
      w_r2[i]  = {{(W+2){1'b0}}, r_s1_r[i]} * {{(W+2){1'b0}}, r_s1_r[i]};
`ifdef CIRCLE_RING_EN
      w_ri2[i] = {{(W+2){1'b0}}, r_s1_ri[i]} * {{(W+2){1'b0}}, r_s1_ri[i]};
`endif
    end
  end

  // Stage 2 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      for (int i = 0; i < N_CIRCLES; i++) begin
        r_s2_dx2[i] <= '0;
        r_s2_dy2[i] <= '0;
        r_s2_r2[i]  <= '0;
`ifdef CIRCLE_RING_EN
        r_s2_ri2[i] <= '0;
`endif
      end
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int i = 0; i < N_CIRCLES; i++) begin
          r_s2_dx2[i] <= w_dx2[i];
          r_s2_dy2[i] <= w_dy2[i];
          r_s2_r2[i]  <= w_r2[i];
`ifdef CIRCLE_RING_EN
          r_s2_ri2[i] <= w_ri2[i];
`endif
        end
      end
    end
  end

  // Stage 3 compare; strict '<' keeps the rim outside and makes r=0 never hit
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_CIRCLES; i++) begin
      w_d2[i] = {1'b0, r_s2_dx2[i]} + {1'b0, r_s2_dy2[i]};
`ifdef CIRCLE_RING_EN
      w_hit[i] = (w_d2[i] < {1'b0, r_s2_r2[i]}) && (w_d2[i] >= {1'b0, r_s2_ri2[i]});
`else
      w_hit[i] = (w_d2[i] < {1'b0, r_s2_r2[i]});
`endif
    end
  end

  // Output register: flags load only with a valid result, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_in_circle <= '0;
      r_any_hit   <= 1'b0;
    end else begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_in_circle <= w_hit;
        r_any_hit   <= |w_hit;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign in_circle = r_in_circle;
  assign any_hit   = r_any_hit;

endmodule

// File: tb/tb_circle_hit_pipe.sv
// Bench for circle_hit_pipe: directed and random points checked against an
// integer-arithmetic model through an expected-result queue.
module tb_circle_hit_pipe;
  localparam int W = 10;
  localparam int N = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] x = '0, y = '0, cfg_cx = '0, cfg_cy = '0, cfg_r = '0, cfg_ri = '0;
  logic         in_valid = 1'b0, cfg_we = 1'b0;
  logic [3:0]   cfg_idx = '0;
  logic         out_valid, any_hit;
  logic [N-1:0] in_circle;

  circle_hit_pipe #(.W(W), .N_CIRCLES(N), .DEF_CX(320), .DEF_CY(240), .DEF_R(64)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .in_valid(in_valid),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_r(cfg_r),
`ifdef CIRCLE_RING_EN
    .cfg_ri(cfg_ri),
`endif
    .out_valid(out_valid), .in_circle(in_circle), .any_hit(any_hit)
  );

  // Scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q[$];
  int           stamp_q[$];
  logic [N-1:0] last_exp = '0;

  // Reference model: circle parameters as plain integers
  int m_cx[N], m_cy[N], m_r[N], m_ri[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cx[i] = 320; m_cy[i] = 240; m_r[i] = 64; m_ri[i] = 0;
    end
  endtask

  function automatic logic [N-1:0] model_hits(int px, int py);
    logic [N-1:0] h;
    h = '0;
    for (int i = 0; i < N; i++) begin
      int dx, dy, d2;
      dx = px - m_cx[i];
      dy = py - m_cy[i];
      d2 = dx*dx + dy*dy;
      h[i] = (d2 < m_r[i]*m_r[i]) && (d2 >= m_ri[i]*m_ri[i]);
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Driver: present one cycle of inputs, predict the result, then update the model
  task automatic drive(input logic v, input int px, input int py, input logic we,
                       input int idx, input int cx, input int cy, input int r, input int ri);
    @(negedge clk);
    in_valid = v; x = W'(px); y = W'(py);
    cfg_we = we; cfg_idx = 4'(idx); cfg_cx = W'(cx); cfg_cy = W'(cy); cfg_r = W'(r); cfg_ri = W'(ri);
    if (v && !reset) begin
      exp_q.push_back(model_hits(px, py));
      stamp_q.push_back(cyc + 3);
    end
    if (we && !reset && idx < N) begin
      m_cx[idx] = cx; m_cy[idx] = cy; m_r[idx] = r;
`ifdef CIRCLE_RING_EN
      m_ri[idx] = ri;
`endif
    end
  endtask

  task automatic point(input int px, input int py);
    drive(1'b1, px, py, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops and compares whenever out_valid is seen, checks hold otherwise
  always @(posedge clk) begin
    #1;
    if (stamp_q.size() > 0 && stamp_q[0] < cyc) begin
      check("missing_out_valid", 32'(stamp_q[0]), 32'(cyc));
      void'(stamp_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (reset) begin
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_in_circle", 32'(in_circle), 32'd0);
      check("reset_any_hit", 32'(any_hit), 32'd0);
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        logic [N-1:0] e;
        int st;
        e = exp_q.pop_front();
        st = stamp_q.pop_front();
        check("latency", 32'(cyc), 32'(st));
        check("in_circle", 32'(in_circle), 32'(e));
        check("any_hit", 32'(any_hit), 32'(|e));
        last_exp = e;
      end
    end else begin
      check("hold_in_circle", 32'(in_circle), 32'(last_exp));
      check("hold_any_hit", 32'(any_hit), 32'(|last_exp));
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Defaults: inside, outside (then hold), rim excluded, just inside rim
    point(360, 240);
    idle(4);
    point(10, 10);
    idle(5);
    point(384, 240);
    point(383, 240);
    point(320, 240);
    idle(4);

    // Reprogram circle 2 in the same cycle as a sample, then repeat the sample
    drive(1'b1, 12, 12, 1'b1, 2, 10, 10, 5, 0);
    point(12, 12);
    // Out-of-range index must be ignored
    drive(1'b1, 12, 12, 1'b1, 5, 12, 12, 100, 0);
    point(12, 12);
    idle(4);

    // Reset mid-stream: two samples captured, then async reset after the second edge
    point(360, 240);
    point(12, 12);
    @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.delete();
    stamp_q.delete();
    last_exp = '0;
    model_reset();
    point(383, 240);
    point(12, 12);
    point(360, 240);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    point(360, 240);
    point(12, 12);
    idle(4);

`ifdef CIRCLE_RING_EN
    // Annulus on circle 0
    drive(1'b0, 0, 0, 1'b1, 0, 320, 240, 64, 32);
    point(330, 240);
    point(360, 240);
    point(352, 240);
    point(384, 240);
    drive(1'b0, 0, 0, 1'b1, 1, 320, 240, 20, 40);
    point(330, 240);
    idle(4);
`endif

    // Randomized stream with interleaved configuration writes
    repeat (400) begin
      logic v, we;
      int r;
      v  = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 400));
      drive(v, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            we, int'($urandom_range(0, 5)),
            int'($urandom_range(150, 850)), int'($urandom_range(150, 850)),
            r, int'($urandom_range(0, 300)));
    end
    idle(6);

    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
